// File: rtl/timer_soc_pkg.sv
// Shared types and default timing constants for the TimerSoC button front end.
package timer_soc_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;  // 20 ms
  localparam int unsigned HOLD_CYCLES_DEF     = CLK_HZ / 2;   // 500 ms
  localparam int unsigned REPEAT_CYCLES_DEF   = CLK_HZ / 10;  // 100 ms

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_HELD,
    BTN_RPT
  } btn_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, counter debounce, edge pulses and hold-to-repeat FSM.
module button_channel
  import timer_soc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1_q;
  logic             s2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             flip_c;
  logic             rise_c;
  logic             fall_c;

  // Level flips on the cycle the mismatch run would reach the debounce count.
  assign flip_c = (s2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise_c = flip_c & ~level_q;
  assign fall_c = flip_c &  level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= ~btn_raw_n;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= rise_c;
      release_q <= fall_c;
      if (s2_q == level_q) begin
        cnt_q <= '0;
      end else if (flip_c) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int unsigned HOLD_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    btn_state_t        state_q;
    btn_state_t        state_d;
    logic [HOLD_W-1:0] hcnt_q;
    logic [HOLD_W-1:0] hcnt_d;
    logic              rpt_q;
    logic              rpt_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= BTN_IDLE;
        hcnt_q  <= '0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        rpt_q   <= rpt_d;
      end
    end

    // A release edge overrides any expiry on the same cycle.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      rpt_d   = 1'b0;
      case (state_q)
        BTN_IDLE: begin
          if (rise_c) begin
            state_d = BTN_HELD;
            hcnt_d  = '0;
          end
        end
        BTN_HELD: begin
          if (hcnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            rpt_d   = 1'b1;
            hcnt_d  = '0;
            state_d = BTN_RPT;
          end else begin
            hcnt_d = hcnt_q + HOLD_W'(1);
          end
        end
        BTN_RPT: begin
          if (hcnt_q == HOLD_W'(REPEAT_CYCLES - 1)) begin
            rpt_d  = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = BTN_IDLE;
          hcnt_d  = '0;
        end
      endcase
      if (fall_c) begin
        state_d = BTN_IDLE;
        hcnt_d  = '0;
        rpt_d   = 1'b0;
      end
    end

    assign repeat_pulse = rpt_q;
  end else begin : g_no_rpt
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions active-low raw push-buttons into clean active-high levels and event pulses.
module button_conditioner
  import timer_soc_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [N_BUTTONS-1:0] btn_raw_n,
  output logic [N_BUTTONS-1:0] buttons_export,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_EN)
    ) u_ch (
      .clk          (clk_clk),
      .rst_n        (reset_reset_n),
      .btn_raw_n    (btn_raw_n[i]),
      .level        (buttons_export[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i]),
      .repeat_pulse (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a window-based reference model.
module tb_button_conditioner;

  localparam int unsigned N    = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned RPT  = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw_n = '1;

  logic [N-1:0] a_lvl, a_press, a_rel, a_rep;
  logic [N-1:0] b_lvl, b_press, b_rel, b_rep;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(RPT), .REPEAT_EN(1)
  ) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .btn_raw_n(raw_n),
    .buttons_export(a_lvl), .btn_press(a_press), .btn_release(a_rel), .btn_repeat(a_rep)
  );

  button_conditioner #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(RPT), .REPEAT_EN(0)
  ) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .btn_raw_n(raw_n),
    .buttons_export(b_lvl), .btn_press(b_press), .btn_release(b_rel), .btn_repeat(b_rep)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // Reference model: ph[c][k] is the pressed sample taken k edges ago. The
  // synchroniser delays by two edges, so a level change needs the samples
  // 2..DEB+1 edges back to all disagree with the current level.
  bit           ph      [N][DEB+2];
  bit           lvl     [N];
  int           press_t [N];
  logic [N-1:0] e_lvl, e_press, e_rel, e_rep;
  bit           flip;
  int           d;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < DEB + 2; k++) ph[c][k] = 1'b0;
      lvl[c]     = 1'b0;
      press_t[c] = 0;
    end
    e_lvl = '0; e_press = '0; e_rel = '0; e_rep = '0;
  endtask

  always begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < N; c++) begin
        flip = 1'b1;
        for (int k = 2; k <= DEB + 1; k++) if (ph[c][k] == lvl[c]) flip = 1'b0;
        e_press[c] = 1'b0;
        e_rel[c]   = 1'b0;
        e_rep[c]   = 1'b0;
        if (flip) begin
          if (!lvl[c]) begin
            lvl[c]     = 1'b1;
            e_press[c] = 1'b1;
            press_t[c] = cyc;
          end else begin
            lvl[c]   = 1'b0;
            e_rel[c] = 1'b1;
          end
        end else if (lvl[c]) begin
          d = cyc - press_t[c];
          e_rep[c] = (d == HOLD) || (d > HOLD && ((d - HOLD) % RPT) == 0);
        end
        for (int k = DEB + 1; k >= 2; k--) ph[c][k] = ph[c][k-1];
        ph[c][1] = ~raw_n[c];
        e_lvl[c] = lvl[c];
      end
    end
    #1;
    check("level_a",   a_lvl,   e_lvl);
    check("press_a",   a_press, e_press);
    check("release_a", a_rel,   e_rel);
    check("repeat_a",  a_rep,   e_rep);
    check("level_b",   b_lvl,   e_lvl);
    check("press_b",   b_press, e_press);
    check("release_b", b_rel,   e_rel);
    check("repeat_b",  b_rep,   '0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int run [N];

  initial begin
    model_reset();

    // Held through reset: outputs quiet, then a fresh press 6 edges after release.
    rst_n = 1'b0;
    raw_n = 2'b00;
    tick(3);
    check("rst_level",   a_lvl,   2'b00);
    check("rst_press",   a_press, 2'b00);
    check("rst_repeat",  a_rep,   2'b00);
    rst_n = 1'b1;
    tick(5);
    check("rst_press_early", a_press, 2'b00);
    tick(1);
    check("rst_press_edge",  a_press, 2'b11);
    check("rst_level_edge",  a_lvl,   2'b11);
    raw_n = 2'b11;
    tick(20);

    // Clean press and release.
    raw_n[0] = 1'b0;
    tick(5);
    check("clean_press_early", a_press, 2'b00);
    tick(1);
    check("clean_press",       a_press, 2'b01);
    check("clean_level",       a_lvl,   2'b01);
    tick(1);
    check("clean_press_width", a_press, 2'b00);
    tick(18);
    raw_n[0] = 1'b1;
    tick(5);
    check("clean_release_early", a_rel, 2'b00);
    tick(1);
    check("clean_release",       a_rel, 2'b01);
    check("clean_release_level", a_lvl, 2'b00);
    tick(1);
    check("clean_release_width", a_rel, 2'b00);
    tick(10);

    // Bounce then settle pressed; later a short glitch must not release.
    for (int i = 0; i < 6; i++) begin
      raw_n[0] = 1'(i % 2);
      tick(2);
    end
    raw_n[0] = 1'b0;
    tick(5);
    check("bounce_press_early", a_press, 2'b00);
    tick(1);
    check("bounce_press", a_press, 2'b01);
    tick(3);
    raw_n[0] = 1'b1;
    tick(3);
    raw_n[0] = 1'b0;
    tick(10);
    check("glitch_hold", a_lvl, 2'b01);
    raw_n[0] = 1'b1;
    tick(20);

    // Auto-repeat timing.
    raw_n[0] = 1'b0;
    tick(6);
    check("rpt_press", a_press, 2'b01);
    tick(9);
    check("rpt_before_first", a_rep, 2'b00);
    tick(1);
    check("rpt_first",  a_rep, 2'b01);
    tick(3);
    check("rpt_second", a_rep, 2'b01);
    tick(1);
    check("rpt_gap",    a_rep, 2'b00);
    tick(15);
    raw_n[0] = 1'b1;
    tick(20);

    // Release accepted on the same edge as the first repeat.
    raw_n[0] = 1'b0;
    tick(6);
    check("coll_press", a_press, 2'b01);
    tick(4);
    raw_n[0] = 1'b1;
    tick(6);
    check("coll_release", a_rel, 2'b01);
    check("coll_repeat",  a_rep, 2'b00);
    tick(10);

    // Both buttons together; the no-repeat build stays silent.
    raw_n = 2'b00;
    tick(6);
    check("both_press_a", a_press, 2'b11);
    check("both_press_b", b_press, 2'b11);
    tick(40);
    check("norpt_repeat", b_rep, 2'b00);
    raw_n = 2'b11;
    tick(10);

    // Random bouncing on both channels with one mid-run reset.
    for (int c = 0; c < N; c++) run[c] = 1;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        rst_n = 1'b0;
        #1;
        check("midrst_level_a", a_lvl,   2'b00);
        check("midrst_rel_a",   a_rel,   2'b00);
        check("midrst_level_b", b_lvl,   2'b00);
        tick(3);
        rst_n = 1'b1;
      end
      for (int c = 0; c < N; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          raw_n[c] = ~raw_n[c];
          run[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 45))
                                               : int'($urandom_range(1, 8));
        end
      end
      tick(1);
    end

    raw_n = 2'b11;
    tick(12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
